// File: rtl/mips_pkg.sv
// ----------------------------------------------------------------------------
// mips_pkg
// Shared constants for the register-address datapath.
//   REG_ADDR_W : width of a register-file address
//   RA_REG     : link register ($31) written by jal/jalr
//   dst_sel_e  : encoding of the writeback-destination select
// ----------------------------------------------------------------------------
package mips_pkg;

   localparam int REG_ADDR_W = 5;

   localparam logic [REG_ADDR_W-1:0] RA_REG = 5'd31;

   // The destination select drives mux_n_pipe input index.
   // DST_ZERO is a spare slot, normally tied to $0.
   typedef enum logic [1:0] {
      DST_RT   = 2'd0,
      DST_RD   = 2'd1,
      DST_RA   = 2'd2,
      DST_ZERO = 2'd3
   } dst_sel_e;

endpackage : mips_pkg

// File: rtl/pipe_stage_reg.sv
// ----------------------------------------------------------------------------
// pipe_stage_reg
// One pipeline register with the Reset > flush > stall > load priority.
// Ports:
//   Clk   : rising-edge clock
//   Reset : synchronous, active-high clear
//   flush : clears the register (squashes the entry)
//   stall : holds the current contents
//   d     : next-stage value
//   q     : registered value
// ----------------------------------------------------------------------------
module pipe_stage_reg #(
   parameter int W = 7
) (
   input  logic         Clk,
   input  logic         Reset,
   input  logic         flush,
   input  logic         stall,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   // A flushed entry is cleared in full (data included), so a flush looks
   // exactly like a reset from the outside and flush outranks stall.
   always_ff @(posedge Clk) begin
      // NOTE: sequential state is written with non-blocking assignments so
      // that every stage samples its neighbour's pre-edge value.
      if (Reset || flush) begin
         q <= '0;
      end else if (!stall) begin
         q <= d;
      end
   end

endmodule : pipe_stage_reg

// File: rtl/mux_n_pipe.sv
// ----------------------------------------------------------------------------
// mux_n_pipe
// N-input selector followed by a DEPTH-stage register pipeline. Each stage
// carries {data, valid, err}. Used for the writeback destination pick
// (rt / rd / $31 / spare) between decode and writeback.
// Ports:
//   Clk       : rising-edge clock
//   Reset     : synchronous, active-high reset
//   data_in   : NUM_IN packed inputs, input i at [i*WIDTH +: WIDTH]
//   select    : input index
//   in_valid  : current select/data belongs to a real instruction
//   stall     : freeze every stage
//   flush     : squash every in-flight entry
//   data_out  : data from the last stage
//   out_valid : valid bit from the last stage
//   sel_err   : last stage holds a valid entry with an out-of-range select
// ----------------------------------------------------------------------------
module mux_n_pipe
   import mips_pkg::*;
#(
   parameter int               WIDTH       = REG_ADDR_W,
   parameter int               NUM_IN      = 4,
   parameter int               SEL_W       = 2,
   parameter int               DEPTH       = 2,
   parameter logic [WIDTH-1:0] DEFAULT_VAL = '0
) (
   input  logic                    Clk,
   input  logic                    Reset,
   input  logic [NUM_IN*WIDTH-1:0] data_in,
   input  logic [SEL_W-1:0]        select,
   input  logic                    in_valid,
   input  logic                    stall,
   input  logic                    flush,
   output logic [WIDTH-1:0]        data_out,
   output logic                    out_valid,
   output logic                    sel_err
);

   // Stage word layout: {data, valid, err}.
   localparam int STG_W = WIDTH + 2;

   // ------------------------------------------------------------------------
   // Elaboration-time parameter checks
   // ------------------------------------------------------------------------
   if (DEPTH < 1) begin : g_bad_depth
      $error("mux_n_pipe: DEPTH must be at least 1");
   end
   if (NUM_IN < 2) begin : g_bad_num_in
      $error("mux_n_pipe: NUM_IN must be at least 2");
   end
   if ((2 ** SEL_W) < NUM_IN) begin : g_bad_sel_w
      $error("mux_n_pipe: SEL_W too narrow to address NUM_IN inputs");
   end

   // ------------------------------------------------------------------------
   // Combinational pick
   // ------------------------------------------------------------------------
   logic [WIDTH-1:0] sel_val;
   logic             raw_err;
   logic             hit;

   // A select that matches no input index falls back to DEFAULT_VAL, so an
   // out-of-range select never propagates X. When every select code maps to
   // an input, hit is always 1 and raw_err reduces to constant 0.
   always_comb begin
      // NOTE: every variable gets a default before the loop; otherwise a
      // select with no matching index would leave it unassigned and infer a
      // latch.
      sel_val = DEFAULT_VAL;
      hit     = 1'b0;
      for (int i = 0; i < NUM_IN; i++) begin
         if (select == SEL_W'(i)) begin
            sel_val = data_in[i*WIDTH +: WIDTH];
            hit     = 1'b1;
         end
      end
      raw_err = ~hit;
   end

   // ------------------------------------------------------------------------
   // Register pipeline
   // ------------------------------------------------------------------------
   logic [STG_W-1:0] stage_q [DEPTH];

   for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      logic [STG_W-1:0] stage_d;

      if (k == 0) begin : g_first
         // An invalid entry still carries its data, but never an error.
         assign stage_d = {sel_val, in_valid, raw_err & in_valid};
      end else begin : g_next
         assign stage_d = stage_q[k-1];
      end

      pipe_stage_reg #(
         .W (STG_W)
      ) u_reg (
         .Clk   (Clk),
         .Reset (Reset),
         .flush (flush),
         .stall (stall),
         .d     (stage_d),
         .q     (stage_q[k])
      );
   end

   // Outputs come straight from the last register: no input-to-output path.
   assign data_out  = stage_q[DEPTH-1][STG_W-1:2];
   assign out_valid = stage_q[DEPTH-1][1];
   assign sel_err   = stage_q[DEPTH-1][0];

endmodule : mux_n_pipe

// File: tb/tb_mux_n_pipe.sv
// ----------------------------------------------------------------------------
// tb_mux_n_pipe
// Directed bench for mux_n_pipe. Three builds share clock and controls:
//   u_dut   : NUM_IN=4, DEPTH=2 (main build)
//   u_dut3  : NUM_IN=3, SEL_W=2, DEPTH=2 (out-of-range select)
//   u_dut1  : NUM_IN=4, DEPTH=1 (single stage)
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
// ----------------------------------------------------------------------------
module tb_mux_n_pipe;
   import mips_pkg::*;

   logic        Clk;
   logic        Reset;
   logic [19:0] data_in4;
   logic [14:0] data_in3;
   logic [1:0]  select;
   logic        in_valid;
   logic        stall;
   logic        flush;

   logic [4:0]  data_out, data_out3, data_out1;
   logic        out_valid, out_valid3, out_valid1;
   logic        sel_err, sel_err3, sel_err1;

   int vectors;
   int miscompares;

   mux_n_pipe #(.WIDTH(5), .NUM_IN(4), .SEL_W(2), .DEPTH(2), .DEFAULT_VAL(5'd0)) u_dut (
      .Clk(Clk), .Reset(Reset), .data_in(data_in4), .select(select),
      .in_valid(in_valid), .stall(stall), .flush(flush),
      .data_out(data_out), .out_valid(out_valid), .sel_err(sel_err)
   );

   mux_n_pipe #(.WIDTH(5), .NUM_IN(3), .SEL_W(2), .DEPTH(2), .DEFAULT_VAL(5'd0)) u_dut3 (
      .Clk(Clk), .Reset(Reset), .data_in(data_in3), .select(select),
      .in_valid(in_valid), .stall(stall), .flush(flush),
      .data_out(data_out3), .out_valid(out_valid3), .sel_err(sel_err3)
   );

   mux_n_pipe #(.WIDTH(5), .NUM_IN(4), .SEL_W(2), .DEPTH(1), .DEFAULT_VAL(5'd0)) u_dut1 (
      .Clk(Clk), .Reset(Reset), .data_in(data_in4), .select(select),
      .in_valid(in_valid), .stall(stall), .flush(flush),
      .data_out(data_out1), .out_valid(out_valid1), .sel_err(sel_err1)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // Check the main build's three outputs at once.
   task automatic check_main(input string tag, input logic [4:0] d,
                             input logic v, input logic e);
      check({tag, ".data"},  32'(data_out),  32'(d));
      check({tag, ".valid"}, 32'(out_valid), 32'(v));
      check({tag, ".err"},   32'(sel_err),   32'(e));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vectors     = 0;
      miscompares = 0;
      Reset    = 1'b1;
      stall    = 1'b0;
      flush    = 1'b0;
      data_in4 = {RA_REG, 5'd17, 5'd9, 5'd3};
      data_in3 = {5'd17, 5'd9, 5'd3};
      select   = DST_RD;
      in_valid = 1'b1;

      // ---- 1: reset held two edges, then first value after two edges ----
      tick();
      check_main("rst_e1", 5'd0, 1'b0, 1'b0);
      tick();
      check_main("rst_e2", 5'd0, 1'b0, 1'b0);
      Reset = 1'b0;
      tick();
      check_main("rel_e1", 5'd0, 1'b0, 1'b0);
      tick();
      check_main("rel_e2", 5'd9, 1'b1, 1'b0);

      // ---- 2: streaming selects 0,1,2,3 ----
      // stage0 holds 9 (select 1 captured again on the previous edge).
      select = 2'd0; tick(); check_main("str_a", 5'd9,  1'b1, 1'b0);
      select = 2'd1; tick(); check_main("str_b", 5'd3,  1'b1, 1'b0);
      select = 2'd2; tick(); check_main("str_c", 5'd9,  1'b1, 1'b0);
      select = 2'd3; tick(); check_main("str_d", 5'd17, 1'b1, 1'b0);
      select = 2'd2; tick(); check_main("str_e", 5'd31, 1'b1, 1'b0);
      // stage0 now holds 17, stage1 holds 31.

      // ---- 3: stall for three edges while select moves to 0 ----
      stall  = 1'b1;
      select = 2'd0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_main($sformatf("stall_%0d", i), 5'd31, 1'b1, 1'b0);
      end
      stall  = 1'b0;
      select = 2'd3;
      tick(); check_main("resume_a", 5'd17, 1'b1, 1'b0);
      select = 2'd1;
      tick(); check_main("resume_b", 5'd31, 1'b1, 1'b0);
      // stage0 holds 9, stage1 holds 31: two valid entries in flight.

      // ---- 4: flush together with stall ----
      flush  = 1'b1;
      stall  = 1'b1;
      select = 2'd2;
      tick(); check_main("flush", 5'd0, 1'b0, 1'b0);
      flush    = 1'b0;
      stall    = 1'b0;
      in_valid = 1'b0;
      select   = 2'd0;
      tick(); check_main("post_flush_a", 5'd0, 1'b0, 1'b0);
      // Invalid entry still shifts its data; the flushed 17 never surfaces.
      tick(); check_main("post_flush_b", 5'd3, 1'b0, 1'b0);

      // ---- 5: NUM_IN=3 build, out-of-range select ----
      select   = 2'd2;
      in_valid = 1'b1;
      tick();
      select   = 2'd3;
      tick();
      check("n3_in_range.data", 32'(data_out3), 32'd17);
      check("n3_in_range.err",  32'(sel_err3),  32'd0);
      in_valid = 1'b0;
      tick();
      check("n3_oor.data",  32'(data_out3),  32'd0);
      check("n3_oor.valid", 32'(out_valid3), 32'd1);
      check("n3_oor.err",   32'(sel_err3),   32'd1);
      tick();
      check("n3_oor_inv.data",  32'(data_out3),  32'd0);
      check("n3_oor_inv.valid", 32'(out_valid3), 32'd0);
      check("n3_oor_inv.err",   32'(sel_err3),   32'd0);

      // ---- 6: DEPTH=1 build, then reset during stall ----
      select   = DST_RA;
      in_valid = 1'b1;
      tick();
      check("d1.data",  32'(data_out1),  32'd17);
      check("d1.valid", 32'(out_valid1), 32'd1);
      select = DST_RT;
      tick();
      check("d1_next.data", 32'(data_out1), 32'd3);
      check_main("pre_rst", 5'd17, 1'b1, 1'b0);
      Reset = 1'b1;
      stall = 1'b1;
      tick();
      check("d1_rst.data",  32'(data_out1),  32'd0);
      check("d1_rst.valid", 32'(out_valid1), 32'd0);
      check_main("rst_stall", 5'd0, 1'b0, 1'b0);
      Reset = 1'b0;
      stall = 1'b0;
      select = DST_RD;
      tick();
      check("d1_after_rst.data", 32'(data_out1), 32'd9);
      check_main("after_rst", 5'd0, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_mux_n_pipe

// File: doc/mux_n_pipe.md
Name: mux_n_pipe

Overview:
Parametrised N-input selector with a registered pipeline of configurable depth. It is the successor to the 2:1 register-address selector. Its first job is the write-register destination pick (rt / rd / $31 for link / spare) between decode and writeback. It also tracks a valid bit and an illegal-select flag, and supports stall and flush so it can sit inside the pipeline with hazard control.

Parameters:
WIDTH, 5, bit width of each data input and of data_out
NUM_IN, 4, number of data inputs (2..16)
SEL_W, 2, select width; must satisfy 2**SEL_W >= NUM_IN
DEPTH, 2, number of register stages between input and output (1..4)
DEFAULT_VAL, 0, value substituted when select >= NUM_IN

Ports:
Clk  input  1  rising-edge clock
Reset  input  1  synchronous, active-high reset
data_in  input  NUM_IN*WIDTH  packed inputs; input i occupies bits [i*WIDTH +: WIDTH]
select  input  SEL_W  chooses input index
in_valid  input  1  current select/data is a real instruction
stall  input  1  hold all stages (pipeline freeze)
flush  input  1  squash all in-flight entries
data_out  output  WIDTH  value from last stage
out_valid  output  1  valid bit from last stage
sel_err  output  1  last stage was loaded with an out-of-range select while valid

Behaviour:
- One clock, Clk. Reset is synchronous and active-high (Reset). All state changes only on the rising edge of Clk.
- Combinational pick:
  - sel_val = input[select] when select < NUM_IN.
  - Otherwise sel_val = DEFAULT_VAL and raw_err = 1.
  - No X ever propagates.
- Stage k (k = 0..DEPTH-1) holds {data, valid, err}. Stage 0 loads {sel_val, in_valid, raw_err & in_valid}. Stage k loads from stage k-1.
- Outputs are driven directly from stage DEPTH-1; no combinational path from inputs to outputs.
- Latency: a value presented at edge n appears on data_out after edge n+DEPTH-1 (i.e. DEPTH edges to load), provided there is no stall.
- Priority at each edge, in order Reset > flush > stall > advance:
  - Reset: every stage's data = 0, valid = 0, err = 0. So data_out = 0, out_valid = 0, sel_err = 0.
  - flush: every stage's valid = 0 and err = 0. Data fields are also cleared to 0. Inputs offered that cycle are discarded.
  - stall (no flush): all stages hold their contents. Inputs are not captured.
  - otherwise: shift one stage.
- Reset asserted mid-operation: state is cleared on the next edge regardless of stall or flush. The first capture happens on the first edge with Reset = 0.
- Simultaneous stall and flush: flush wins; the pipeline empties.
- An invalid entry (in_valid = 0) still shifts its data through. Its err is forced to 0.
- Output data is only meaningful when out_valid = 1.
- Parameter checks at elaboration:
  - DEPTH < 1, NUM_IN < 2, or 2**SEL_W < NUM_IN must stop elaboration with an error.
  - When NUM_IN = 2**SEL_W, raw_err is constant 0.

Decomposition:
- Shared package mips_pkg:
  - REG_ADDR_W = 5
  - RA_REG = 5'd31
  - select encodings DST_RT = 0, DST_RD = 1, DST_RA = 2, DST_ZERO = 3
- Sub-module pipe_stage_reg:
  - One parametrised WIDTH+2-bit register with Reset/flush/stall priority.
  - Instantiated DEPTH times in a generate loop.
  - The selector logic stays in the top.

Test Plan:
1. Reset held 2 cycles with data_in = {5'd31, 5'd17, 5'd9, 5'd3} (i3..i0), select = 1, in_valid = 1, DEPTH = 2 → data_out = 0, out_valid = 0, sel_err = 0 throughout. After release, the 2nd edge gives data_out = 9, out_valid = 1.
2. Streaming selects 0, 1, 2, 3 on consecutive cycles, no stall → data_out = 3, 9, 17, 31 on consecutive cycles, starting 2 edges after the first capture.
3. Stall held 3 cycles while select changes to 0 → data_out and out_valid frozen at the pre-stall values. After release, the sequence resumes with no lost or duplicated entry.
4. flush and stall both asserted for one edge with two valid entries in flight → out_valid = 0 and data_out = 0 on the next edge. The entry offered during the flush never appears.
5. NUM_IN = 3, SEL_W = 2, select = 3, in_valid = 1 → after DEPTH edges, data_out = DEFAULT_VAL (0) and sel_err = 1. The same test with in_valid = 0 gives sel_err = 0.
6. DEPTH = 1 build, select = 2 → data_out = 17 one edge later. Reset asserted in the same cycle as a stall clears all outputs on that edge.
